// File: rtl/spike_sink_arbiter_if.sv
// Handshake bundle between the PE requesters and the shared result sink.
//   in_valid/in_data/in_ready : per-requester packet offer and one-hot accept
//   out_valid/out_data/out_src/out_ready : packet presented to the single sink
// slave modport is the arbiter side, master modport is the requester/sink side.
interface spike_sink_arbiter_if #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/spike_sink_arbiter.sv
// Round-robin arbiter sharing one result sink among NUM_REQ PE requesters.
// Each transfer is followed by HOLDOFF idle cycles (sink service delay).
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   bus (slave)      : requester offers, one-hot in_ready, sink packet/handshake
//   busy             : high while a packet is held or the hold-off runs
//   transfer_count   : sink acceptances since reset (wrapping)
//   last_gap         : cycles between the two most recent acceptances
module spike_sink_arbiter #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned GAP_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    spike_sink_arbiter_if.slave bus,
    output logic                busy,
    output logic [CNT_W-1:0]    transfer_count,
    output logic [GAP_W-1:0]    last_gap
);
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [SRC_W-1:0]    rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [SRC_W-1:0]    scan_idx;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_found;
    logic                take;
    logic                accept;

    // First valid requester at or after rr_ptr; index arithmetic wraps
    // naturally because NUM_REQ is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + SRC_W'(k);
            if (!grant_found && bus.in_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, combinational grant and handshake strobes.
    always_comb begin
        state_n      = state;
        bus.in_ready = '0;
        take         = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    bus.in_ready = NUM_REQ'(1) << grant_idx;
                    take         = 1'b1;
                    state_n      = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    accept  = 1'b1;
                    state_n = (HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Packet register, pointer, hold-off and performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= '0;
            hold_cnt       <= '0;
            gap_cnt        <= '0;
            busy           <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_src    <= '0;
            transfer_count <= '0;
            last_gap       <= '0;
        end else begin
            busy <= (state_n != IDLE);
            if (take) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
                bus.out_src   <= grant_idx;
                rr_ptr        <= grant_idx + SRC_W'(1);
            end
            if (accept) begin
                bus.out_valid  <= 1'b0;
                transfer_count <= transfer_count + CNT_W'(1);
                last_gap       <= gap_cnt;
                gap_cnt        <= GAP_W'(1);
                hold_cnt       <= (HOLDOFF != 0) ? HOLD_W'(HOLDOFF - 1) : '0;
            end else if (gap_cnt != '1) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spike_sink_arbiter.sv
// Self-checking bench for spike_sink_arbiter: directed sequences, a grant
// table, a HOLDOFF=0 instance and a randomized run against a pending-packet /
// countdown model of the sink protocol.
module tb_spike_sink_arbiter;
    localparam int unsigned WIDTH   = 12;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned GAP_W   = 16;
    localparam int          HOLD0   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spike_sink_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus0 ();
    spike_sink_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus1 ();

    logic             busy0, busy1;
    logic [CNT_W-1:0] tc0, tc1;
    logic [GAP_W-1:0] lg0, lg1;

    spike_sink_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .HOLDOFF(HOLD0),
                         .CNT_W(CNT_W), .GAP_W(GAP_W)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .busy(busy0), .transfer_count(tc0), .last_gap(lg0)
    );

    spike_sink_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .HOLDOFF(0),
                         .CNT_W(CNT_W), .GAP_W(GAP_W)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .busy(busy1), .transfer_count(tc1), .last_gap(lg1)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus0.in_valid = '0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = '0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (busy0 && n < 20) begin
            cyc();
            n++;
        end
        chk("idle_wait", 64'(busy0), 64'd0);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    // Randomized-run model state
    int          m_pkt, m_src, m_wait, m_next, m_gap, m_last;
    logic [11:0] m_data;
    int unsigned m_cnt;
    int          req_v [4];
    logic [11:0] req_d [4];

    initial begin
        int          g;
        int          gq [$];
        int          cq [$];
        logic [63:0] tcb;

        tbl[0] = '{4'b0001, 4'b0001, 2'd0};
        tbl[1] = '{4'b1111, 4'b0010, 2'd1};
        tbl[2] = '{4'b1001, 4'b1000, 2'd3};
        tbl[3] = '{4'b1001, 4'b0001, 2'd0};
        tbl[4] = '{4'b0100, 4'b0100, 2'd2};
        tbl[5] = '{4'b0110, 4'b0010, 2'd1};
        tbl[6] = '{4'b1000, 4'b1000, 2'd3};
        tbl[7] = '{4'b0000, 4'b0000, 2'd0};

        // Reset state and single transfer with hold-off
        do_reset();
        chk("rst_busy", 64'(busy0), 0);
        chk("rst_out_valid", 64'(bus0.out_valid), 0);
        chk("rst_out_data", 64'(bus0.out_data), 0);
        chk("rst_out_src", 64'(bus0.out_src), 0);
        chk("rst_tc", 64'(tc0), 0);
        chk("rst_lg", 64'(lg0), 0);
        chk("rst_in_ready", 64'(bus0.in_ready), 0);
        bus0.in_valid = 4'b0001;
        bus0.in_data[0 +: 12] = 12'h0A5;
        bus0.out_ready = 1'b1;
        #1;
        chk("a_in_ready", 64'(bus0.in_ready), 64'h1);
        cyc();
        bus0.in_data[0 +: 12] = 12'h1B6;
        #1;
        chk("a_out_valid", 64'(bus0.out_valid), 1);
        chk("a_out_data", 64'(bus0.out_data), 64'h0A5);
        chk("a_out_src", 64'(bus0.out_src), 0);
        chk("a_send_ready", 64'(bus0.in_ready), 0);
        chk("a_send_busy", 64'(busy0), 1);
        cyc();
        chk("a_tc", 64'(tc0), 1);
        chk("a_lg", 64'(lg0), 1);
        chk("a_acc_valid", 64'(bus0.out_valid), 0);
        chk("a_hold1_ready", 64'(bus0.in_ready), 0);
        chk("a_hold1_busy", 64'(busy0), 1);
        cyc();
        chk("a_hold2_ready", 64'(bus0.in_ready), 0);
        chk("a_hold2_busy", 64'(busy0), 1);
        cyc();
        chk("a_idle_ready", 64'(bus0.in_ready), 64'h1);
        chk("a_idle_busy", 64'(busy0), 0);
        bus0.in_valid = '0;

        // Grant-order table
        do_reset();
        bus0.out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            wait_idle0();
            bus0.in_valid = tbl[r].valid;
            for (int i = 0; i < 4; i++) bus0.in_data[i*12 +: 12] = 12'(r*16 + i);
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(bus0.in_ready), 64'(tbl[r].exp_ready));
            cyc();
            bus0.in_valid = '0;
            #1;
            if (tbl[r].exp_ready != 4'b0000) begin
                chk($sformatf("tbl%0d_src", r), 64'(bus0.out_src), 64'(tbl[r].exp_src));
                chk($sformatf("tbl%0d_data", r), 64'(bus0.out_data), 64'(r*16 + int'(tbl[r].exp_src)));
                cyc();
            end else begin
                chk($sformatf("tbl%0d_novalid", r), 64'(bus0.out_valid), 0);
            end
        end

        // All requesters continuously valid: 0,1,2,3,0,1 every 4 cycles
        do_reset();
        bus0.in_valid = 4'b1111;
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #1;
            g = onehot_idx(bus0.in_ready);
            if (g >= 0) begin gq.push_back(g); cq.push_back(c); end
            cyc();
            if (g >= 0) bus0.in_data[g*12 +: 12] = 12'(c);
        end
        chk("b_tc", 64'(tc0), 6);
        chk("b_lg", 64'(lg0), 4);
        chk("b_ngrants", 64'(gq.size()), 6);
        for (int k = 0; k < 6 && k < gq.size(); k++) begin
            chk($sformatf("b_grant%0d", k), 64'(gq[k]), 64'(k % 4));
            chk($sformatf("b_cycle%0d", k), 64'(cq[k]), 64'(4 * k));
        end

        // Sink stalls for 10 cycles while a packet is held
        do_reset();
        bus0.in_valid = 4'b0100;
        bus0.in_data[2*12 +: 12] = 12'h3C7;
        #1;
        cyc();
        bus0.in_valid = '0;
        for (int c = 0; c < 10; c++) begin
            chk("c_valid", 64'(bus0.out_valid), 1);
            chk("c_data", 64'(bus0.out_data), 64'h3C7);
            chk("c_src", 64'(bus0.out_src), 2);
            chk("c_ready", 64'(bus0.in_ready), 0);
            cyc();
        end
        tcb = 64'(tc0);
        bus0.out_ready = 1'b1;
        cyc();
        chk("c_tc_inc", 64'(tc0), tcb + 1);
        chk("c_gap_ge11", 64'(lg0 >= 11), 1);
        repeat (4) cyc();
        chk("c_tc_once", 64'(tc0), tcb + 1);

        // Asynchronous reset while a packet is held (counters nonzero here)
        wait_idle0();
        bus0.out_ready = 1'b0;
        bus0.in_valid = 4'b0010;
        bus0.in_data[1*12 +: 12] = 12'h2D4;
        #1;
        chk("d_ready", 64'(bus0.in_ready), 64'h2);
        cyc();
        bus0.in_valid = '0;
        chk("d_valid_pre", 64'(bus0.out_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk("d_async_valid", 64'(bus0.out_valid), 0);
        chk("d_async_busy", 64'(busy0), 0);
        chk("d_async_tc", 64'(tc0), 0);
        chk("d_async_lg", 64'(lg0), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus0.in_valid = 4'b1111;
        bus0.out_ready = 1'b1;
        #1;
        chk("d_first_grant", 64'(bus0.in_ready), 64'h1);
        cyc();
        chk("d_first_src", 64'(bus0.out_src), 0);

        // HOLDOFF=0 instance: grant/accept alternate every cycle
        do_reset();
        bus1.in_valid = 4'b1111;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("e_busy%0d", k), 64'(busy1), 64'(k % 2));
            chk($sformatf("e_ready%0d", k), 64'(bus1.in_ready),
                (k % 2 == 0) ? (64'd1 << ((k / 2) % 4)) : 64'd0);
            cyc();
        end
        chk("e_tc", 64'(tc1), 6);
        chk("e_lg", 64'(lg1), 2);

        // Randomized traffic against the protocol model
        do_reset();
        m_pkt = 0; m_src = 0; m_wait = 0; m_next = 0; m_gap = 0; m_last = 0;
        m_data = '0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin req_v[i] = 0; req_d[i] = '0; end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req_v[i] == 0) begin
                    if ($urandom_range(2) == 0) begin
                        req_v[i] = 1;
                        req_d[i] = 12'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    req_v[i] = 0;
                end
                bus0.in_valid[i] = (req_v[i] != 0);
                bus0.in_data[i*12 +: 12] = req_d[i];
            end
            bus0.out_ready = ($urandom_range(3) != 0);
            #1;
            g = -1;
            if (m_pkt == 0 && m_wait == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_v[(m_next + k) % 4] != 0) g = (m_next + k) % 4;
                end
            end
            chk("r_in_ready", 64'(bus0.in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("r_out_valid", 64'(bus0.out_valid), 64'(m_pkt));
            if (m_pkt != 0) begin
                chk("r_out_data", 64'(bus0.out_data), 64'(m_data));
                chk("r_out_src", 64'(bus0.out_src), 64'(m_src));
            end
            chk("r_busy", 64'(busy0), 64'(m_pkt != 0 || m_wait > 0));
            chk("r_tc", 64'(tc0), 64'(m_cnt));
            chk("r_lg", 64'(lg0), 64'(m_last));
            if (m_pkt != 0 && bus0.out_ready) begin
                m_pkt = 0;
                m_cnt++;
                m_last = m_gap;
                m_gap = 1;
                m_wait = HOLD0;
            end else begin
                if (g >= 0) begin
                    m_pkt = 1;
                    m_src = g;
                    m_data = req_d[g];
                    m_next = (g + 1) % 4;
                    req_v[g] = 0;
                end else if (m_wait > 0) begin
                    m_wait--;
                end
                if (m_gap < 65535) m_gap++;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
